uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter for 8N1 framing with one or two stop bits: LSB first, idle-high line. It accepts a byte over a valid/ready handshake and serialises it at a fixed bit period of KBAUD clock cycles. It is the transmit counterpart of the team's UART receiver, and pairs with it in the communication library for loopback and host links.

## Interface
- KBAUD, 14'd10416: clock cycles per bit; legal range ≥ 2
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2
- clk  input  1  system clock; all logic on its rising edge
- rst  input  1  synchronous reset, active-low. One clock, and reset is synchronous and active-low.
- in_data  input  8  byte to send; sampled only on accept
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a byte this cycle; reset value 0, 1 from first cycle after reset release
- out_tx  output  1  serial line; reset value 1 (idle)
- busy  output  1  frame in progress (state ≠ IDLE); reset value 0
- tx_done  output  1  one-cycle pulse at the last cycle of the final stop bit; reset value 0

## Operation
- FSM states and transitions:
  - IDLE → START on accept
  - START → DATA after KBAUD cycles
  - DATA → (PARITY if enabled) → STOP after 8 bits of KBAUD cycles each
  - STOP → IDLE, or STOP → START on back-to-back accept
- Accept = in_valid & in_ready. On accept, in_data is latched into an 8-bit shift register and the bit counter is cleared.
- in_ready = 1 in IDLE, and also in the last cycle of the final stop bit, to allow gapless streaming. It is 0 otherwise.
- out_tx is registered:
  - START drives 0
  - DATA drives shift_reg[0]; the register shifts right at each bit boundary
  - STOP drives 1
  - IDLE drives 1
- Baud counter:
  - Width $clog2(KBAUD); counts 0 to KBAUD-1.
  - The bit boundary is the cycle where the count equals KBAUD-1.
  - Clears to 0 on accept.
- Bit counter: 3 bits in DATA; DATA exits when it equals 7 at a bit boundary.
- Stop counter: with STOP_BITS=2, STOP lasts 2·KBAUD cycles.
- Reset during a frame: on the next edge, state is IDLE, out_tx=1 and busy=0. No tx_done is emitted and the byte is discarded.
- in_valid while in_ready=0 is ignored. The source must hold in_data stable until it is accepted.

## Timing
- Accept at edge N → out_tx falls at edge N+1. Start bit occupies cycles N+1 … N+KBAUD.
- Data bit k occupies cycles N+1+(k+1)·KBAUD … N+(k+2)·KBAUD.
- Frame length: (10 + STOP_BITS − 1 + P)·KBAUD cycles, where P=1 with parity enabled and 0 otherwise.
- tx_done and the final in_ready are high in the same cycle, the last of the stop bit.
- An accept in that cycle starts the next start bit on the following edge, so there are zero idle cycles between frames.
- busy rises at N+1 and falls the cycle after tx_done unless a back-to-back accept occurs.

## Configuration
- UART_TX_PARITY_EN defined:
  - adds a PARITY state between DATA and STOP, lasting KBAUD cycles;
  - the bit driven is even parity, the XOR of the 8 latched data bits, computed at accept.
- Undefined: no PARITY state, pure 8N1/8N2, and no parity logic is synthesised.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP), 2- or 3-bit as needed;
  - the DATA_BITS=8 localparam;
  - the line-level constants LINE_IDLE=1 and START_LVL=0.
- The enum is also usable by the receiver.
- One sub-module, uart_baud_gen:
  - parameter KBAUD;
  - inputs clk, rst, clr, en;
  - output tick, a one-cycle pulse at count KBAUD-1.
- The FSM, shift register and handshake live in uart_tx.

## Test plan
All scenarios use KBAUD=16 and STOP_BITS=1 unless noted.
- Reset: hold rst=0 for 3 cycles, then release. → out_tx=1, busy=0, tx_done=0 throughout; in_ready=1 from the first cycle after release.
- Single byte 8'h41: accept at cycle N → out_tx pattern 0,1,0,0,0,0,0,1,0,1 with each bit 16 cycles wide; tx_done pulses exactly once at N+160.
- Back-to-back 8'h55 then 8'hAA with in_valid held high → second start bit begins at N+161, with no idle cycles on out_tx; two tx_done pulses, 160 cycles apart.
- STOP_BITS=2, byte 8'hFF → stop high for 32 cycles; tx_done at N+176.
- Reset mid-frame: rst=0 during data bit 3 → out_tx=1 and busy=0 the next cycle, no tx_done; a new 8'h0F then transmits correctly.
- UART_TX_PARITY_EN with byte 8'h07 (three 1s) → parity bit = 1 after bit 7; tx_done at N+176. With byte 8'h03 → parity bit = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and line-level constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter, ticks on the last cycle of each bit
module uart_baud_gen #(
  parameter int unsigned KBAUD = 10416
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned      CW   = $clog2(KBAUD);
  localparam logic [CW-1:0]    LAST = CW'(KBAUD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1/8N2 UART transmitter with valid/ready byte input
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned KBAUD     = 14'd10416,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_tx,
  output logic       busy,
  output logic       tx_done
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e state, state_next;
  logic [7:0]  shift_reg, shift_next;
  logic [2:0]  bit_cnt, bit_next;
  logic        stop_idx, stop_next;
  logic        line_next;
  logic        ready_en;
  logic        tick;
  logic        accept;
  logic        final_stop;

  uart_baud_gen #(.KBAUD(KBAUD)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (busy),
    .tick (tick)
  );

`ifdef UART_TX_PARITY_EN
  logic parity_bit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= ^in_data;
    end
  end
`endif

  assign busy       = (state != IDLE);
  assign final_stop = (state == STOP) && tick && (stop_idx == LAST_STOP);
  assign tx_done    = final_stop;
  // ready_en holds in_ready low for the whole reset and lifts it on the first free cycle
  assign in_ready   = ready_en && ((state == IDLE) || final_stop);
  assign accept     = in_valid && in_ready;

  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    bit_next   = bit_cnt;
    stop_next  = stop_idx;
    line_next  = LINE_IDLE;

    case (state)
      IDLE: ;
      START: begin
        if (tick) state_next = DATA;
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
            stop_next  = 1'b0;
          end else begin
            bit_next   = bit_cnt + 3'd1;
            shift_next = shift_reg >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_next = STOP;
          stop_next  = 1'b0;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (stop_idx == LAST_STOP) state_next = IDLE;
          else                       stop_next  = stop_idx + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // accept is only possible in IDLE or the final stop cycle, so it overrides either
    if (accept) begin
      state_next = START;
      shift_next = in_data;
      bit_next   = 3'd0;
    end

    case (state_next)
      START:   line_next = START_LVL;
      DATA:    line_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_next = parity_bit;
`endif
      default: line_next = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      stop_idx  <= 1'b0;
      out_tx    <= LINE_IDLE;
      ready_en  <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= bit_next;
      stop_idx  <= stop_next;
      out_tx    <= line_next;
      ready_en  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx, one and two stop bit instances
module tb_uart_tx;

  localparam int K = 16;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       valid1, valid2;
  logic       ready1, tx1, busy1, done1;
  logic       ready2, tx2, busy2, done2;
  logic       sel;
  logic       o_ready, o_tx, o_busy, o_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tx_q[$];

  always #5 clk = ~clk;

  uart_tx #(.KBAUD(K), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid1),
    .in_ready(ready1), .out_tx(tx1), .busy(busy1), .tx_done(done1)
  );

  uart_tx #(.KBAUD(K), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(valid2),
    .in_ready(ready2), .out_tx(tx2), .busy(busy2), .tx_done(done2)
  );

  assign o_ready = sel ? ready2 : ready1;
  assign o_tx    = sel ? tx2    : tx1;
  assign o_busy  = sel ? busy2  : busy1;
  assign o_done  = sel ? done2  : done1;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Line level t cycles after the accept cycle, from the frame layout alone
  function automatic logic exp_line(input logic [7:0] b, input int t);
    int slot;
    slot = (t - 1) / K;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (P == 1 && slot == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic set_valid(input logic v);
    if (sel) valid2 = v;
    else     valid1 = v;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_line"},  o_tx,    1'b1);
    check({tag, "_busy"},  o_busy,  1'b0);
    check({tag, "_done"},  o_done,  1'b0);
    check({tag, "_ready"}, o_ready, 1'b1);
  endtask

  // Sends every byte in tx_q back to back, checking each cycle of every frame
  task automatic send_queue(input int stops);
    int         len;
    logic [7:0] b;
    bit         more;
    len  = (10 + stops - 1 + P) * K;
    more = 1'b1;
    check("ready_before", o_ready, 1'b1);
    b = tx_q.pop_front();
    in_data = b;
    set_valid(1'b1);
    while (more) begin
      for (int t = 1; t <= len; t++) begin
        @(negedge clk);
        if (t == 1) begin
          if (tx_q.size() > 0) in_data = tx_q[0];
          else                 set_valid(1'b0);
        end
        check("line",  o_tx,    exp_line(b, t));
        check("busy",  o_busy,  1'b1);
        check("done",  o_done,  (t == len));
        check("ready", o_ready, (t == len));
      end
      if (tx_q.size() > 0) b = tx_q.pop_front();
      else                 more = 1'b0;
    end
    @(negedge clk);
    check_idle("after");
  endtask

  initial begin
    rst = 1'b0; valid1 = 1'b0; valid2 = 1'b0; in_data = 8'h00; sel = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_line",  o_tx,    1'b1);
      check("rst_busy",  o_busy,  1'b0);
      check("rst_done",  o_done,  1'b0);
      check("rst_ready", o_ready, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle("release");
    sel = 1'b1;
    check("release_ready2", o_ready, 1'b1);
    sel = 1'b0;

    tx_q.push_back(8'h41);
    send_queue(1);

    tx_q.push_back(8'h55);
    tx_q.push_back(8'hAA);
    send_queue(1);

    sel = 1'b1;
    tx_q.push_back(8'hFF);
    send_queue(2);
    sel = 1'b0;

    // reset in the middle of data bit 3
    in_data = 8'hC3;
    valid1  = 1'b1;
    check("mid_ready", o_ready, 1'b1);
    for (int t = 1; t <= 4 * K + 5; t++) begin
      @(negedge clk);
      if (t == 1) valid1 = 1'b0;
      check("mid_line", o_tx, exp_line(8'hC3, t));
    end
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_line",  o_tx,    1'b1);
    check("mid_rst_busy",  o_busy,  1'b0);
    check("mid_rst_done",  o_done,  1'b0);
    check("mid_rst_ready", o_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_idle("mid_release");
    tx_q.push_back(8'h0F);
    send_queue(1);

    tx_q.push_back(8'h07);
    send_queue(1);
    tx_q.push_back(8'h03);
    send_queue(1);

    for (int i = 0; i < 4; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    send_queue(1);

    sel = 1'b1;
    for (int i = 0; i < 2; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    send_queue(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
